// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for handshaked pipeline stage registers: stage FSM states and
// per-boundary payload widths so instances can use DATA_W = MEM_WB_W etc.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } stage_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [63:0] rs1Val;
        logic [63:0] rs2Val;
        logic [63:0] imm;
        logic [7:0]  ctrl;
    } decode_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [63:0] aluResult;
        logic [63:0] storeData;
        logic [7:0]  ctrl;
    } execute_data_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] wbData;
        logic        regWrite;
    } memory_data_t;

    localparam int unsigned IF_ID_W  = $bits(fetch_data_t);
    localparam int unsigned ID_EX_W  = $bits(decode_data_t);
    localparam int unsigned EX_MEM_W = $bits(execute_data_t);
    localparam int unsigned MEM_WB_W = $bits(memory_data_t);

    function automatic logic [1:0] occupancyOf(input stage_state_t s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating stall/bubble counter pair for a pipeline stage output port.
module pipe_stage_perf #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             outValid,
    input  logic             outReady,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] bubbleCnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt  <= '0;
            bubbleCnt <= '0;
        end else begin
            if (outValid && !outReady && stallCnt != '1)
                stallCnt <= stallCnt + 1'b1;
            if (!outValid && bubbleCnt != '1)
                bubbleCnt <= bubbleCnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with 2-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt counter ports.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W         = 64,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    if (DATA_W < 1 || CNT_W < 1) begin : gBadParam
        $error("pipe_stage_reg: DATA_W and CNT_W must be at least 1");
    end

    stage_state_t      state;
    stage_state_t      nextState;
    logic [DATA_W-1:0] skidData;
    logic              acc;
    logic              drn;

    assign out_valid = (state != EMPTY);
    assign occupancy = occupancyOf(state);

    always_comb begin
        acc       = in_valid && in_ready;
        drn       = out_valid && out_ready;
        nextState = state;
        if (flush) begin
            nextState = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (acc) nextState = ONE;
                ONE:     if (acc && !drn) nextState = FULL;
                         else if (!acc && drn) nextState = EMPTY;
                FULL:    if (drn) nextState = ONE;
                default: nextState = EMPTY;
            endcase
        end
    end

    // in_ready is a register fed by the next state so upstream sees no comb path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            out_data <= '0;
            skidData <= '0;
        end else begin
            state    <= nextState;
            in_ready <= (nextState != FULL);
            if (flush) begin
                if (CLEAR_ON_FLUSH) begin
                    out_data <= '0;
                    skidData <= '0;
                end
            end else begin
                case (state)
                    EMPTY:   if (acc) out_data <= in_data;
                    ONE:     if (acc && drn) out_data <= in_data;
                             else if (acc) skidData <= in_data;
                    FULL:    if (drn) out_data <= skidData;
                    default: ;
                endcase
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_perf #(
        .CNT_W(CNT_W)
    ) uPerf (
        .clk      (clk),
        .reset    (reset),
        .outValid (out_valid),
        .outReady (out_ready),
        .stallCnt (stall_cnt),
        .bubbleCnt(bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based FIFO model.
// Counter checks are active when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W(DW),
        .CLEAR_ON_FLUSH(1'b1),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of capacity 2 with a registered ready.
    logic [DW-1:0] q[$];
    bit            expReady = 1'b0;
    bit            dataZero = 1'b1;
    int unsigned   stallM = 0;
    int unsigned   bubbleM = 0;
    int unsigned   accepted = 0;
    int unsigned   delivered = 0;
    int unsigned   checks = 0;
    int unsigned   errors = 0;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit iv, input logic [DW-1:0] d,
                        input bit ordy);
        bit acc;
        bit drn;
        int unsigned n;
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        n   = q.size();
        acc = iv && expReady;
        drn = (n > 0) && ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            expReady = 1'b0;
            dataZero = 1'b1;
            stallM   = 0;
            bubbleM  = 0;
        end else begin
            if (n > 0 && !ordy && stallM < CNT_MAX) stallM++;
            if (n == 0 && bubbleM < CNT_MAX) bubbleM++;
            if (acc || drn) dataZero = 1'b0;
            if (drn) begin
                void'(q.pop_front());
                delivered++;
            end
            if (f) begin
                q.delete();
                dataZero = 1'b1;
            end else if (acc) begin
                q.push_back(d);
                accepted++;
            end
            expReady = (q.size() < 2);
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(expReady));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        if (q.size() > 0)
            chk("out_data", 64'(out_data), 64'(q[0]));
        else if (dataZero)
            chk("out_data_zero", 64'(out_data), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stallM));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(bubbleM));
`endif
    endtask

    initial begin
        int unsigned cycles;

        // Reset held with traffic presented; in_ready rises one edge after release.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 16'h00AA, 0);
        step(0, 0, 0, 16'h0000, 0);

        // Streaming with downstream always ready.
        for (int i = 1; i <= 8; i++) step(0, 0, 1, DW'(i), 1);
        step(0, 0, 0, '0, 1);

        // Back-pressure: 0x10, 0x11 fill the stage, 0x12 waits upstream.
        step(0, 0, 1, 16'h0010, 0);
        step(0, 0, 1, 16'h0011, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0012, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 16'h0012, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);

        // Flush while full with an offered beat: everything dropped, data zeroed.
        step(0, 0, 1, 16'h0020, 0);
        step(0, 0, 1, 16'h0021, 0);
        step(0, 1, 1, 16'h0022, 0);
        step(0, 0, 0, '0, 1);
        // Flush with downstream ready while full: only the handed-off head survives.
        step(0, 0, 1, 16'h0030, 0);
        step(0, 0, 1, 16'h0031, 0);
        step(0, 1, 1, 16'h0032, 1);
        step(0, 0, 0, '0, 1);

        // Mid-transfer reset.
        step(0, 0, 1, 16'h0040, 0);
        step(1, 1, 1, 16'h0041, 1);
        step(0, 0, 0, '0, 0);

        // Counter saturation: three idle cycles, then one held item for 20 cycles.
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0);
        step(0, 0, 1, 16'h0050, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, '0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, '0, 1);

        // Random valid/ready/flush traffic until 1000 more items are accepted.
        begin
            int unsigned target;
            target = accepted + 1000;
            cycles = 0;
            while (accepted < target && cycles < 20000) begin
                step(0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                     DW'($urandom), ($urandom_range(0, 2) != 0));
                cycles++;
            end
            chk("random_budget", 64'(accepted >= target), 64'd1);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);
        chk("final_occupancy", 64'(occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
